custom_ip_reg_sched: RTL

Register-access scheduler for the custom IP's register interface: six registers, three writable (0–2) and three read-only (3–5). It arbitrates between NUM_REQ requesters, such as the AXI slave front end and a debug port, with round-robin fairness. For the accepted request it drives the IP's per-register write-enable/ack and read-valid handshakes with a bounded timeout, then returns a single-cycle response to the owning requester. It keeps shadow copies of the writable registers so their values can be read back.

---
 rtl/custom_ip_reg_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/custom_ip_reg_sched.sv
// Round-robin register-access scheduler in front of the custom IP's six registers.
// Keeps shadow copies of writable registers 0-2 and waits a bounded time for IP handshakes.
module custom_ip_reg_sched #(
   parameter int NUM_REQ = 2,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [NUM_REQ-1:0]    req_we_i,
   input  logic [NUM_REQ*3-1:0]  req_addr_i,
   input  logic [NUM_REQ*DW-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   output logic [DW-1:0]         rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [2:0]            ip_wr_en_o,
   output logic [DW-1:0]         ip_wr_data_o,
   input  logic [2:0]            ip_wr_ack_i,
   input  logic [3*DW-1:0]       ip_rd_data_i,
   input  logic [2:0]            ip_rd_valid_i,
   output logic                  busy_o
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WR_WAIT = 2'd1;
   localparam logic [1:0] RD_WAIT = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   logic [1:0]    state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic [PW-1:0] winner;
   logic          found;
   logic [2:0]    addr;
   logic [CW-1:0] wait_cnt;
   logic [DW-1:0] shadow [3];
   logic          acc_we;
   logic [2:0]    acc_addr;
   logic [DW-1:0] acc_wdata;
   logic [1:0]    rd_idx;
   logic [DW-1:0] rd_word;
   logic          wr_hit;
   logic          rd_hit;
   logic          wait_last;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // First valid requester at or after rr_ptr, wrapping around
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         int idx;
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!found && req_valid_i[idx]) begin
            found  = 1'b1;
            winner = idx[PW-1:0];
         end
      end
   end

   assign req_ready_o = (state == IDLE && found) ? onehot(winner) : '0;
   assign acc_we      = req_we_i[winner];
   assign acc_addr    = req_addr_i[int'(winner)*3 +: 3];
   assign acc_wdata   = req_wdata_i[int'(winner)*DW +: DW];

   always_comb begin
      case (addr)
         3'd4:    rd_idx = 2'd1;
         3'd5:    rd_idx = 2'd2;
         default: rd_idx = 2'd0;
      endcase
   end

   // The enable vector is one-hot on the target, so masking with it ignores acks for other registers
   assign wr_hit    = |(ip_wr_ack_i & ip_wr_en_o);
   assign rd_hit    = ip_rd_valid_i[rd_idx];
   assign rd_word   = ip_rd_data_i[int'(rd_idx)*DW +: DW];
   assign wait_last = (wait_cnt == CW'(TIMEOUT - 1));
   assign busy_o    = (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         addr         <= '0;
         wait_cnt     <= '0;
         rsp_valid_o  <= '0;
         rsp_rdata_o  <= '0;
         rsp_err_o    <= 1'b0;
         ip_wr_en_o   <= '0;
         ip_wr_data_o <= '0;
         for (int i = 0; i < 3; i++) shadow[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  owner    <= winner;
                  addr     <= acc_addr;
                  wait_cnt <= '0;
                  rr_ptr   <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                  if (acc_we && acc_addr <= 3'd2) begin
                     state        <= WR_WAIT;
                     ip_wr_en_o   <= 3'b001 << acc_addr[1:0];
                     ip_wr_data_o <= acc_wdata;
                  end else if (!acc_we && acc_addr >= 3'd3 && acc_addr <= 3'd5) begin
                     state <= RD_WAIT;
                  end else begin
                     // Shadow reads and decode errors answer without touching the IP
                     state       <= RESP;
                     rsp_valid_o <= onehot(winner);
                     if (!acc_we && acc_addr <= 3'd2) begin
                        rsp_rdata_o <= shadow[acc_addr[1:0]];
                        rsp_err_o   <= 1'b0;
                     end else begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                     end
                  end
               end
            end
            WR_WAIT: begin
               if (wr_hit || wait_last) begin
                  if (wr_hit) shadow[addr[1:0]] <= ip_wr_data_o;
                  ip_wr_en_o  <= '0;
                  state       <= RESP;
                  rsp_valid_o <= onehot(owner);
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= !wr_hit;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RD_WAIT: begin
               if (rd_hit || wait_last) begin
                  state       <= RESP;
                  rsp_valid_o <= onehot(owner);
                  rsp_rdata_o <= rd_hit ? rd_word : '0;
                  rsp_err_o   <= !rd_hit;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               state       <= IDLE;
               rsp_valid_o <= '0;
               rsp_rdata_o <= '0;
               rsp_err_o   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
